// File: rtl/fixed_square.sv
// fixed_square: iterative shift-add squarer for unsigned Q8.8 operands.
// Produces the full Q16.16 square plus a saturated 8-bit integer square.
// Each request takes exactly 16 CALC steps, then one DONE cycle.
// Optional build macro: FIXED_SQUARE_ROUND_EN rounds the integer result half up
// before saturation; without it the integer result is truncated.
module fixed_square (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in,
  output logic        busy,
  output logic        done,
  output logic [31:0] sq,
  output logic [7:0]  out,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        accept_s;
  logic [31:0] mcand_r;
  logic [15:0] mplr_r;
  logic [31:0] acc_r;
  logic [4:0]  cnt_r;
  logic [31:0] addend_s;
  logic [16:0] r_s;
  logic        ovf_s;
  logic        busy_r;
  logic        done_r;
  logic [31:0] sq_r;
  logic [7:0]  out_r;
  logic        ovf_r;

  assign busy = busy_r;
  assign done = done_r;
  assign sq   = sq_r;
  assign out  = out_r;
  assign ovf  = ovf_r;

  // Next-state logic; a start coinciding with the done pulse is not accepted.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !done_r) begin
          accept_s = 1'b1;
          state_s  = CALC;
        end else begin
          state_s  = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 5'd15) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Partial product for this step and the rounded/truncated integer candidate.
  always_comb begin
    addend_s = 32'd0;
    if (mplr_r[0]) begin
      addend_s = mcand_r << cnt_r;
    end else begin
      addend_s = 32'd0;
    end
`ifdef FIXED_SQUARE_ROUND_EN
    r_s = {1'b0, acc_r[31:16]} + {16'd0, acc_r[15]};
`else
    r_s = {1'b0, acc_r[31:16]};
`endif
    ovf_s = (r_s > 17'd255);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs; latency is fixed, no early exit on mplr==0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r <= 32'd0;
      mplr_r  <= 16'd0;
      acc_r   <= 32'd0;
      cnt_r   <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sq_r    <= 32'd0;
      out_r   <= 8'd0;
      ovf_r   <= 1'b0;
    end else begin
      busy_r <= (state_r != IDLE);
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_r <= {16'd0, in};
            mplr_r  <= in;
            acc_r   <= 32'd0;
            cnt_r   <= 5'd0;
          end
        end
        CALC: begin
          acc_r  <= acc_r + addend_s;
          mplr_r <= mplr_r >> 1;
          cnt_r  <= cnt_r + 5'd1;
        end
        DONE: begin
          sq_r  <= acc_r;
          ovf_r <= ovf_s;
          if (ovf_s) begin
            out_r <= 8'hFF;
          end else begin
            out_r <= r_s[7:0];
          end
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_square.sv
// Scoreboard bench for fixed_square: stimulus pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_fixed_square;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in;
  logic        busy;
  logic        done;
  logic [31:0] sq;
  logic [7:0]  out;
  logic        ovf;

  fixed_square dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in   (in),
    .busy (busy),
    .done (done),
    .sq   (sq),
    .out  (out),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] sq;
    logic [7:0]  out;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total  = 0;
  int   passed = 0;

`ifdef FIXED_SQUARE_ROUND_EN
  localparam logic [7:0] RND_OUT = 8'd128;
`else
  localparam logic [7:0] RND_OUT = 8'd127;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        check("sq", sq, mon_e.sq);
        check("out", {24'd0, out}, {24'd0, mon_e.out});
        check("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
        check("latency", cyc, mon_e.cyc);
      end
    end
  end

  // Pulse start for one cycle; when accepted, done is due 17 edges after the sampling edge.
  task automatic issue(input logic [15:0] v, input logic [31:0] esq, input logic [7:0] eout,
                       input logic eovf, input bit expect_accept);
    exp_t e;
    @(negedge clk);
    in    = v;
    start = 1'b1;
    if (expect_accept) begin
      e.sq  = esq;
      e.out = eout;
      e.ovf = eovf;
      e.cyc = cyc + 18;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    in    = 16'hA5A5;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL timeout: got %0d results pending required 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [15:0] v, input logic [31:0] esq, input logic [7:0] eout,
                     input logic eovf);
    issue(v, esq, eout, eovf, 1'b1);
    check("busy_after_accept_edge", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("busy_in_calc", {31'd0, busy}, 32'd1);
    wait_idle();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    in    = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sq", sq, 32'd0);
    check("rst_out", {24'd0, out}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(16'h0300, 32'h0009_0000, 8'd9,   1'b0);
    run(16'h0B50, 32'h007F_F900, RND_OUT, 1'b0);
    run(16'h1000, 32'h0100_0000, 8'd255, 1'b1);
    run(16'hFFFF, 32'hFFFE_0001, 8'd255, 1'b1);
    run(16'h0000, 32'h0000_0000, 8'd0,   1'b0);

    // Start while busy is dropped.
    issue(16'h0200, 32'h0004_0000, 8'd4, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    issue(16'h0500, 32'h0019_0000, 8'd25, 1'b0, 1'b0);
    wait_idle();
    repeat (20) @(negedge clk);

    // Start during the done cycle is dropped.
    issue(16'h0300, 32'h0009_0000, 8'd9, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (done !== 1'b1) begin
        total++;
        $display("FAIL done_wait: got done=%b required 1", done);
      end
    end
    in    = 16'h0500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check("busy_after_done_start", {31'd0, busy}, 32'd0);
    q.delete();

    // Reset in the middle of CALC aborts with no done pulse.
    issue(16'h0300, 32'h0, 8'd0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sq", sq, 32'd0);
    check("abort_out", {24'd0, out}, 32'd0);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    run(16'h0300, 32'h0009_0000, 8'd9, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
